// File: rtl/dvsd_pe_stream_if.sv
// Stream bundle for dvsd_pe_stream: request-vector capture channel and encoded-index drain channel.
// The slave modport is the encoder's view; master is the producer/consumer side.
interface dvsd_pe_stream_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out;
    logic             out_last;

    modport master (
        output in_valid,
        output in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out,
        output out_last
    );
endinterface

// File: rtl/dvsd_pe_stream.sv
// Multi-hot priority encoder: captures a request vector, then drains every set bit
// as an encoded index, one per handshake, in MSB-first or LSB-first order.
module dvsd_pe_stream #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    lsb_first,
    dvsd_pe_stream_if.slave         bus,
    output logic [$clog2(WIDTH):0]  cnt,
    output logic                    gs,
    output logic                    eno
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   pending_q;
    logic [WIDTH-1:0]   pending_d;
    logic               mode_q;
    logic [IDX_W:0]     cnt_q;
    logic [IDX_W:0]     cnt_d;
    logic               eno_q;

    logic [WIDTH-1:0]   pend_rev;
    logic [WIDTH-1:0]   low_oh;
    logic [WIDTH-1:0]   high_oh_rev;
    logic [WIDTH-1:0]   high_oh;
    logic [WIDTH-1:0]   sel_oh;
    logic [IDX_W-1:0]   sel_idx;
    logic               last_bit;
    logic               accept;
    logic               beat;
    logic               draining;

    // Highest set bit is found by isolating the lowest set bit of the bit-reversed vector.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign pend_rev[gi] = pending_q[WIDTH-1-gi];
            assign high_oh[gi]  = high_oh_rev[WIDTH-1-gi];
        end
    endgenerate

    assign low_oh      = pending_q & (~pending_q + WIDTH'(1));
    assign high_oh_rev = pend_rev  & (~pend_rev  + WIDTH'(1));
    assign sel_oh      = mode_q ? low_oh : high_oh;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel_oh[i]) begin
                sel_idx = sel_idx | IDX_W'(i);
            end
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d = cnt_d + {{IDX_W{1'b0}}, bus.in[i]};
        end
    end

    // Exactly one bit pending when isolating the lowest bit leaves the vector unchanged.
    assign last_bit  = (pending_q != '0) && (low_oh == pending_q);
    assign pending_d = pending_q & ~sel_oh;

    assign draining      = (state_q == DRAIN);
    assign bus.out_valid = en & draining;
    assign bus.out       = sel_idx;
    assign bus.out_last  = last_bit;
    assign beat          = bus.out_valid & bus.out_ready;
    assign bus.in_ready  = en & (~draining | (beat & last_bit));
    assign accept        = bus.in_valid & bus.in_ready;

    assign cnt = cnt_q;
    assign gs  = draining;
    assign eno = eno_q;

    // A reload accepted on the final beat takes priority over returning to IDLE.
    always_ff @(posedge clk) begin
        eno_q <= 1'b0;
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            mode_q    <= 1'b0;
            cnt_q     <= '0;
        end else if (accept) begin
            pending_q <= bus.in;
            mode_q    <= lsb_first;
            cnt_q     <= cnt_d;
            eno_q     <= (bus.in == '0);
            state_q   <= (bus.in == '0) ? IDLE : DRAIN;
        end else if (beat) begin
            pending_q <= pending_d;
            if (last_bit) begin
                state_q <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dvsd_pe_stream.sv
// Directed and randomized bench for dvsd_pe_stream; a queue of remaining indices models the drain.
module tb_dvsd_pe_stream;
    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             lsb_first;
    logic [IDX_W:0]   cnt;
    logic             gs;
    logic             eno;

    dvsd_pe_stream_if #(.WIDTH(WIDTH)) bus ();

    dvsd_pe_stream #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .lsb_first (lsb_first),
        .bus       (bus.slave),
        .cnt       (cnt),
        .gs        (gs),
        .eno       (eno)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef int iq_t[$];
    iq_t mq;
    int  m_cnt = 0;
    int  m_eno = 0;

    function automatic iq_t order(logic [WIDTH-1:0] v, bit lsb);
        iq_t r;
        int  i;
        for (int k = 0; k < WIDTH; k++) begin
            i = lsb ? k : WIDTH - 1 - k;
            if (v[i]) r.push_back(i);
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model, then advance one clock.
    task automatic step();
        bit m_valid, m_last, m_beat, m_ready, m_acc;
        #1;
        m_valid = en && (mq.size() > 0);
        m_last  = (mq.size() == 1);
        m_beat  = m_valid && bus.out_ready;
        m_ready = en && ((mq.size() == 0) || (m_beat && m_last));
        m_acc   = bus.in_valid && m_ready;
        chk("out_valid", bus.out_valid, m_valid);
        chk("in_ready", bus.in_ready, m_ready);
        chk("out", bus.out, (mq.size() > 0) ? mq[0] : 0);
        chk("out_last", bus.out_last, m_last);
        chk("gs", gs, mq.size() > 0);
        chk("cnt", cnt, m_cnt);
        chk("eno", eno, m_eno);
        @(posedge clk);
        m_eno = 0;
        if (reset) begin
            mq.delete();
            m_cnt = 0;
        end else if (m_acc) begin
            mq    = order(bus.in, lsb_first);
            m_cnt = $countones(bus.in);
            m_eno = (bus.in == '0);
        end else if (m_beat) begin
            void'(mq.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        int seq_msb[4];
        int seq_lsb[4];
        seq_msb = '{7, 5, 2, 0};
        seq_lsb = '{0, 2, 5, 7};

        reset = 1'b1; en = 1'b1; lsb_first = 1'b0;
        bus.in_valid = 1'b0; bus.in = '0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state, then a single one-hot request.
        bus.in_valid = 1'b1; bus.in = 8'b0001_0000;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_gs", gs, 0);
        chk("rst_eno", eno, 0);
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("oh_out", bus.out, 4);
        chk("oh_last", bus.out_last, 1);
        chk("oh_cnt", cnt, 1);
        chk("oh_gs", gs, 1);
        step();
        #1;
        chk("oh_gs_drop", gs, 0);
        step();

        // Multi-hot in both priority orders.
        for (int m = 0; m < 2; m++) begin
            bus.in_valid = 1'b1; bus.in = 8'b1010_0101; lsb_first = (m == 1);
            step();
            bus.in_valid = 1'b0; lsb_first = (m == 0);
            for (int k = 0; k < 4; k++) begin
                #1;
                chk("mh_out", bus.out, (m == 1) ? seq_lsb[k] : seq_msb[k]);
                chk("mh_last", bus.out_last, k == 3);
                chk("mh_cnt", cnt, 4);
                step();
            end
        end

        // All bits set with a stalling consumer.
        bus.in_valid = 1'b1; bus.in = 8'hFF; lsb_first = 1'b0;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.out_ready = 1'b0;
            #1;
            chk("ff_hold", bus.out, 7 - k);
            step();
            bus.out_ready = 1'b1;
            #1;
            chk("ff_out", bus.out, 7 - k);
            chk("ff_last", bus.out_last, k == 7);
            chk("ff_cnt", cnt, 8);
            step();
        end

        // All-zero vector.
        bus.in_valid = 1'b1; bus.in = 8'h00;
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("z_eno", eno, 1);
        chk("z_cnt", cnt, 0);
        chk("z_in_ready", bus.in_ready, 1);
        chk("z_out_valid", bus.out_valid, 0);
        step();
        #1;
        chk("z_eno_pulse", eno, 0);
        step();

        // Back-to-back vectors without a bubble.
        bus.in_valid = 1'b1; bus.in = 8'b0000_0011;
        step();
        bus.in = 8'b0100_0000;
        #1;
        chk("b2b_out1", bus.out, 1);
        chk("b2b_rdy1", bus.in_ready, 0);
        step();
        #1;
        chk("b2b_out0", bus.out, 0);
        chk("b2b_rdy0", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("b2b_out6", bus.out, 6);
        chk("b2b_valid6", bus.out_valid, 1);
        step();
        step();

        // Enable dropped mid-drain.
        bus.in_valid = 1'b1; bus.in = 8'b1100_0011;
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("en_out7", bus.out, 7);
        step();
        en = 1'b0;
        #1;
        chk("en_valid", bus.out_valid, 0);
        chk("en_gs", gs, 1);
        chk("en_ready", bus.in_ready, 0);
        step();
        step();
        en = 1'b1;
        #1;
        chk("en_out6", bus.out, 6);
        step();
        #1;
        chk("en_out1", bus.out, 1);
        step();
        #1;
        chk("en_out0", bus.out, 0);
        chk("en_last0", bus.out_last, 1);
        step();

        // Reset mid-drain.
        bus.in_valid = 1'b1; bus.in = 8'b1100_0011;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("rd_out1", bus.out, 1);
        step();
        reset = 1'b0;
        #1;
        chk("rd_valid", bus.out_valid, 0);
        chk("rd_gs", gs, 0);
        chk("rd_cnt", cnt, 0);
        step();
        step();

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            en            = ($urandom_range(0, 7) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid  = $urandom_range(0, 1);
            lsb_first     = $urandom_range(0, 1);
            reset         = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 3))
                0:       bus.in = 8'h00;
                1:       bus.in = 8'(1 << $urandom_range(0, 7));
                2:       bus.in = 8'hFF;
                default: bus.in = 8'($urandom);
            endcase
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
